// File: rtl/bluejay_line_packer_if.sv
// ---------------------------------------------------------------------------
// bluejay_line_packer_if
// Bundles the host byte stream, the line FIFO write port and the display-side
// read/status signals of the Bluejay line packer.
//   byte_i / byte_valid_i / byte_ready_o : host byte handshake
//   fifo_full / fifo_wr_en / fifo_data_in : line FIFO write port
//   get_next_word                         : display stage read strobe
//   line_of_data_available, next_frame_rdy, lines_buffered, rd_err_o : status
// Modports: master = surrounding system (host, FIFO, display stage),
//           slave  = the packer itself.
// ---------------------------------------------------------------------------
interface bluejay_line_packer_if #(
  parameter int FIFO_LINES = 4
);
  localparam int LB_W = $clog2(FIFO_LINES + 1);

  logic [7:0]      byte_i;
  logic            byte_valid_i;
  logic            byte_ready_o;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [31:0]     fifo_data_in;
  logic            get_next_word;
  logic            line_of_data_available;
  logic            next_frame_rdy;
  logic [LB_W-1:0] lines_buffered;
  logic            rd_err_o;

  modport master (
    output byte_i, byte_valid_i, fifo_full, get_next_word,
    input  byte_ready_o, fifo_wr_en, fifo_data_in,
           line_of_data_available, next_frame_rdy, lines_buffered, rd_err_o
  );

  modport slave (
    input  byte_i, byte_valid_i, fifo_full, get_next_word,
    output byte_ready_o, fifo_wr_en, fifo_data_in,
           line_of_data_available, next_frame_rdy, lines_buffered, rd_err_o
  );
endinterface

// File: rtl/bluejay_line_packer.sv
// ---------------------------------------------------------------------------
// bluejay_line_packer
// Packs the host byte stream (little-endian, four bytes per word) into 32-bit
// words for the display line FIFO, and tracks how many whole lines are
// buffered and where the display stage is reading within the frame.
// Ports:
//   fpga_clk  : single clock, rising edge
//   reset_all : asynchronous active-low reset
//   bus       : bluejay_line_packer_if.slave (byte handshake, FIFO write port,
//               display read strobe and status outputs)
// ---------------------------------------------------------------------------
module bluejay_line_packer #(
  parameter int WORDS_PER_LINE  = 320,
  parameter int LINES_PER_FRAME = 1280,
  parameter int FIFO_LINES      = 4
) (
  input  logic                  fpga_clk,
  input  logic                  reset_all,
  bluejay_line_packer_if.slave  bus
);

  localparam int LB_W = $clog2(FIFO_LINES + 1);
  localparam int WI_W = (WORDS_PER_LINE  > 1) ? $clog2(WORDS_PER_LINE)  : 1;
  localparam int LI_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  localparam logic [WI_W-1:0] WORD_LAST = WI_W'(WORDS_PER_LINE - 1);
  localparam logic [LI_W-1:0] LINE_LAST = LI_W'(LINES_PER_FRAME - 1);
  localparam logic [WI_W-1:0] WORD_ZERO = {WI_W{1'b0}};
  localparam logic [LI_W-1:0] LINE_ZERO = {LI_W{1'b0}};
  localparam logic [LB_W-1:0] LB_MAX    = LB_W'(FIFO_LINES);
  localparam logic [LB_W-1:0] LB_ZERO   = {LB_W{1'b0}};
  localparam logic [LB_W-1:0] LB_ONE    = LB_W'(1);

  logic [1:0]      byte_cnt_r;
  logic [23:0]     byte_hold_r;      // bytes 0..2 of the word being assembled
  logic [31:0]     word_r;           // completed word presented to the FIFO
  logic            word_valid_r;
  logic [WI_W-1:0] wr_word_idx_r;
  logic [LI_W-1:0] wr_line_idx_r;
  logic [WI_W-1:0] rd_word_idx_r;
  logic [LI_W-1:0] rd_line_idx_r;
  logic [LB_W-1:0] lines_buffered_r;
  logic [LB_W-1:0] lines_buffered_nxt_s;
  logic            rd_err_r;

  logic byte_ready_s;
  logic fifo_wr_en_s;
  logic byte_accept_s;
  logic word_done_s;
  logic wr_line_done_s;
  logic rd_line_done_s;

  // Stall the host only while a finished word is stuck behind a full FIFO;
  // the word register can be refilled in the same cycle it is written out.
  assign byte_ready_s   = ~(word_valid_r & bus.fifo_full);
  assign fifo_wr_en_s   = word_valid_r & ~bus.fifo_full;
  assign byte_accept_s  = bus.byte_valid_i & byte_ready_s;
  assign word_done_s    = byte_accept_s & (byte_cnt_r == 2'd3);
  assign wr_line_done_s = fifo_wr_en_s & (wr_word_idx_r == WORD_LAST);
  assign rd_line_done_s = bus.get_next_word & (rd_word_idx_r == WORD_LAST);

  // Byte assembly and the word register / valid flag.
  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      byte_cnt_r   <= 2'd0;
      byte_hold_r  <= 24'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else begin
      if (byte_accept_s) begin
        case (byte_cnt_r)
          2'd0:    byte_hold_r[7:0]   <= bus.byte_i;
          2'd1:    byte_hold_r[15:8]  <= bus.byte_i;
          2'd2:    byte_hold_r[23:16] <= bus.byte_i;
          default: word_r             <= {bus.byte_i, byte_hold_r};
        endcase
        byte_cnt_r <= byte_cnt_r + 2'd1;  // 3 -> 0 wraps naturally
      end
      if (word_done_s) begin
        word_valid_r <= 1'b1;
      end else if (fifo_wr_en_s) begin
        word_valid_r <= 1'b0;
      end
    end
  end

  // Write-side word/line position within the frame.
  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      wr_word_idx_r <= WORD_ZERO;
      wr_line_idx_r <= LINE_ZERO;
    end else if (fifo_wr_en_s) begin
      if (wr_line_done_s) begin
        wr_word_idx_r <= WORD_ZERO;
        wr_line_idx_r <= (wr_line_idx_r == LINE_LAST) ? LINE_ZERO : wr_line_idx_r + LI_W'(1);
      end else begin
        wr_word_idx_r <= wr_word_idx_r + WI_W'(1);
      end
    end
  end

  // Read-side word/line position; advances even when nothing is buffered.
  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      rd_word_idx_r <= WORD_ZERO;
      rd_line_idx_r <= LINE_ZERO;
    end else if (bus.get_next_word) begin
      if (rd_line_done_s) begin
        rd_word_idx_r <= WORD_ZERO;
        rd_line_idx_r <= (rd_line_idx_r == LINE_LAST) ? LINE_ZERO : rd_line_idx_r + LI_W'(1);
      end else begin
        rd_word_idx_r <= rd_word_idx_r + WI_W'(1);
      end
    end
  end

  // Saturating line count: a simultaneous write and read completion cancel.
  always_comb begin
    lines_buffered_nxt_s = lines_buffered_r;
    case ({wr_line_done_s, rd_line_done_s})
      2'b10: begin
        if (lines_buffered_r != LB_MAX) begin
          lines_buffered_nxt_s = lines_buffered_r + LB_ONE;
        end else begin
          lines_buffered_nxt_s = lines_buffered_r;
        end
      end
      2'b01: begin
        if (lines_buffered_r != LB_ZERO) begin
          lines_buffered_nxt_s = lines_buffered_r - LB_ONE;
        end else begin
          lines_buffered_nxt_s = lines_buffered_r;
        end
      end
      default: lines_buffered_nxt_s = lines_buffered_r;
    endcase
  end

  // Line count register and sticky read-underflow flag.
  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      lines_buffered_r <= LB_ZERO;
      rd_err_r         <= 1'b0;
    end else begin
      lines_buffered_r <= lines_buffered_nxt_s;
      if (bus.get_next_word && (lines_buffered_r == LB_ZERO)) begin
        rd_err_r <= 1'b1;
      end
    end
  end

  assign bus.byte_ready_o           = byte_ready_s;
  assign bus.fifo_wr_en             = fifo_wr_en_s;
  assign bus.fifo_data_in           = word_r;
  assign bus.lines_buffered         = lines_buffered_r;
  assign bus.line_of_data_available = (lines_buffered_r != LB_ZERO);
  assign bus.next_frame_rdy         = (rd_line_idx_r == LINE_ZERO) &
                                      (rd_word_idx_r == WORD_ZERO) &
                                      (lines_buffered_r != LB_ZERO);
  assign bus.rd_err_o               = rd_err_r;

endmodule

// File: tb/tb_bluejay_line_packer.sv
// ---------------------------------------------------------------------------
// tb_bluejay_line_packer
// Directed scenarios plus a randomized phase. The reference model keeps a
// queue of accepted bytes, a queue of completed-but-unwritten words and plain
// running totals of words written/read, from which line completions, the
// buffered-line count, frame alignment and the error flag are derived.
// ---------------------------------------------------------------------------
module tb_bluejay_line_packer;
  localparam int WPL = 4;
  localparam int LPF = 2;
  localparam int FL  = 2;

  logic fpga_clk  = 1'b0;
  logic reset_all = 1'b1;

  bluejay_line_packer_if #(.FIFO_LINES(FL)) bus ();

  bluejay_line_packer #(
    .WORDS_PER_LINE (WPL),
    .LINES_PER_FRAME(LPF),
    .FIFO_LINES     (FL)
  ) dut (
    .fpga_clk (fpga_clk),
    .reset_all(reset_all),
    .bus      (bus)
  );

  always #5 fpga_clk = ~fpga_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_bytes[$];
  logic [31:0] m_words[$];
  int          m_wr_total;
  int          m_rd_total;
  int          m_lines;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_bytes.delete();
    m_words.delete();
    m_wr_total = 0;
    m_rd_total = 0;
    m_lines    = 0;
    m_err      = 1'b0;
  endtask

  task automatic check_status(input string pfx);
    bit nfr_e;
    nfr_e = ((m_rd_total % (WPL * LPF)) == 0) && (m_lines != 0);
    check_eq({pfx, "_lines"}, 32'(bus.lines_buffered), 32'(m_lines));
    check_eq({pfx, "_avail"}, 32'(bus.line_of_data_available), 32'(m_lines != 0));
    check_eq({pfx, "_nfr"},   32'(bus.next_frame_rdy), 32'(nfr_e));
    check_eq({pfx, "_err"},   32'(bus.rd_err_o), 32'(m_err));
  endtask

  // Asserts reset from wherever we are (off any clock edge) and checks that
  // outputs are at reset values before any edge arrives.
  task automatic do_reset();
    reset_all         = 1'b0;
    bus.byte_valid_i  = 1'b0;
    bus.byte_i        = 8'h00;
    bus.fifo_full     = 1'b0;
    bus.get_next_word = 1'b0;
    #1;
    model_clear();
    check_eq("rst_ready", 32'(bus.byte_ready_o), 32'd1);
    check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check_eq("rst_data",  bus.fifo_data_in, 32'd0);
    check_status("rst");
    repeat (2) @(negedge fpga_clk);
    reset_all = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to the state expected after the following rising edge.
  task automatic step(input bit v, input logic [7:0] b, input bit full, input bit get);
    bit ready_e;
    bit we_e;
    bit wl;
    bit rl;
    @(negedge fpga_clk);
    bus.byte_valid_i  = v;
    bus.byte_i        = b;
    bus.fifo_full     = full;
    bus.get_next_word = get;
    #1;
    ready_e = !((m_words.size() != 0) && full);
    we_e    = (m_words.size() != 0) && !full;
    check_eq("byte_ready", 32'(bus.byte_ready_o), 32'(ready_e));
    check_eq("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(we_e));
    if (we_e) check_eq("fifo_data", bus.fifo_data_in, m_words[0]);
    check_status("cyc");

    wl = 1'b0;
    rl = 1'b0;
    if (we_e) begin
      void'(m_words.pop_front());
      m_wr_total++;
      wl = ((m_wr_total % WPL) == 0);
    end
    if (get) begin
      if (m_lines == 0) m_err = 1'b1;
      m_rd_total++;
      rl = ((m_rd_total % WPL) == 0);
    end
    if (wl && !rl && (m_lines < FL)) m_lines++;
    else if (rl && !wl && (m_lines > 0)) m_lines--;
    if (v && ready_e) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        m_words.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
        m_bytes.delete();
      end
    end
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] held;
    bus.byte_valid_i  = 1'b0;
    bus.byte_i        = 8'h00;
    bus.fifo_full     = 1'b0;
    bus.get_next_word = 1'b0;
    model_clear();
    #2;
    do_reset();

    // 1: single word, little-endian, written the cycle after the 4th byte
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("s1_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    check_eq("s1_word",  bus.fifo_data_in, 32'h4433_2211);
    check_eq("s1_ready", 32'(bus.byte_ready_o), 32'd1);

    // 2: rest of a line; count rises the cycle after the 4th write
    send_bytes(12);
    idle(2);
    check_eq("s2_lines", 32'(bus.lines_buffered), 32'd1);
    check_eq("s2_avail", 32'(bus.line_of_data_available), 32'd1);
    check_eq("s2_nfr",   32'(bus.next_frame_rdy), 32'd1);

    // 3: backpressure holds the word and the host
    do_reset();
    step(1'b1, 8'hDE, 1'b0, 1'b0);
    step(1'b1, 8'hAD, 1'b0, 1'b0);
    step(1'b1, 8'hBE, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check_eq("s3_ready_held", 32'(bus.byte_ready_o), 32'd0);
    check_eq("s3_wr_held",    32'(bus.fifo_wr_en), 32'd0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    held = 32'hEFBE_ADDE;
    check_eq("s3_word",   bus.fifo_data_in, held);
    check_eq("s3_wr_rel", 32'(bus.fifo_wr_en), 32'd1);
    check_eq("s3_ready",  32'(bus.byte_ready_o), 32'd1);
    idle(2);

    // 4: reading lines, frame wrap of the read line index
    do_reset();
    send_bytes(16); idle(2);
    read_words(4);  idle(1);
    check_eq("s4_lines0", 32'(bus.lines_buffered), 32'd0);
    check_eq("s4_nfr0",   32'(bus.next_frame_rdy), 32'd0);
    send_bytes(16); idle(2);
    check_eq("s4_nfr_l1", 32'(bus.next_frame_rdy), 32'd0);
    read_words(4);  idle(1);
    send_bytes(16); idle(2);
    check_eq("s4_nfr_wrap", 32'(bus.next_frame_rdy), 32'd1);
    check_eq("s4_err",      32'(bus.rd_err_o), 32'd0);

    // 5: simultaneous completions cancel; saturation at FIFO_LINES
    do_reset();
    send_bytes(16); idle(2);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, i < 3);
    send_bytes(4);
    step(1'b0, 8'h00, 1'b0, 1'b1);   // last write of line 1 with last read of line 0
    idle(1);
    check_eq("s5_same_cycle", 32'(bus.lines_buffered), 32'd1);
    send_bytes(32); idle(2);
    check_eq("s5_saturate", 32'(bus.lines_buffered), 32'd2);

    // 6: underflow read is sticky; asynchronous reset mid-word
    do_reset();
    read_words(1);
    idle(2);
    check_eq("s6_err", 32'(bus.rd_err_o), 32'd1);
    send_bytes(2);
    do_reset();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit v;
      bit f;
      bit g;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      if (m_lines > 0) g = ($urandom_range(0, 2) == 0);
      else             g = ($urandom_range(0, 199) == 0);
      step(v, 8'($urandom_range(0, 255)), f, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
